// File: rtl/slow_clk_monitor_if.sv
// Bundle between the slow-clock source side and the fast-domain monitor.
// Handshake: there is no valid/ready pair here. slow_in is a free-running
// level with no timing relation to clk. Every output is a registered
// clk-domain value. rise_pulse, fall_pulse and period_valid are one-cycle
// strobes that a consumer must act on in the cycle they are high.
// dbg_measure exposes the FSM state: 0 = IDLE, 1 = MEASURE.
interface slow_clk_monitor_if #(
    parameter int unsigned CNT_W = 32
);
    logic             slow_in;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             stalled;
    logic [7:0]       err_count;
    logic             dbg_measure;

    // Source side: drives the slow clock and observes the monitor.
    modport master (
        output slow_in,
        input  rise_pulse, fall_pulse, period, period_valid,
        input  locked, stalled, err_count, dbg_measure
    );

    // Monitor side: samples the slow clock and reports on it.
    modport slave (
        input  slow_in,
        output rise_pulse, fall_pulse, period, period_valid,
        output locked, stalled, err_count, dbg_measure
    );
endinterface

// File: rtl/slow_clk_monitor.sv
// Fast-domain receiver for a divided slow clock. It synchronizes slow_in,
// emits rise/fall strobes, measures each rise-to-rise period in clk cycles,
// tracks lock against EXPECTED +/- TOL, and flags a stalled slow clock.
// Parameter constraints: SYNC_STAGES >= 2, TOL <= EXPECTED, and
// EXPECTED+TOL < TIMEOUT < 2**CNT_W.
module slow_clk_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned EXPECTED    = 100000000,
    parameter int unsigned TOL         = 16,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned TIMEOUT     = 200000000
) (
    input  logic               clk,
    input  logic               rst,
    slow_clk_monitor_if.slave  bus
);

    localparam int unsigned      GW       = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] LO_BOUND = CNT_W'(EXPECTED - TOL);
    localparam logic [CNT_W-1:0] HI_BOUND = CNT_W'(EXPECTED + TOL);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_M1   = CNT_W'(TIMEOUT - 1);
    localparam logic [GW-1:0]    LOCK_V   = GW'(LOCK_COUNT);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_rise;
    logic                   r_fall;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_period;
    logic                   r_period_valid;
    logic                   r_locked;
    logic                   r_stalled;
    logic [7:0]             r_err;
    logic [GW-1:0]          r_good;
    state_t                 r_state;

    logic                   w_sync_out;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_in_tol;
    logic                   w_stall_hit;
    logic [GW-1:0]          w_good_next;
    logic [7:0]             w_err_next;

    // Edge detection on the synchronized level. The strobes are registered
    // so consumers see clean flop outputs, one edge after detection.
    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_sync_out & ~r_hist;
    assign w_fall     = ~w_sync_out & r_hist;

    // Measurement decode: tolerance window, stall point, saturating updates.
    always_comb begin
        w_in_tol    = (r_cnt >= LO_BOUND) && (r_cnt <= HI_BOUND);
        w_stall_hit = ~w_rise && (r_cnt == TMO_M1);
        w_good_next = (r_good == LOCK_V) ? LOCK_V : r_good + 1'b1;
        w_err_next  = (r_err == 8'hFF) ? 8'hFF : r_err + 8'd1;
    end

    // Synchronizer chain, edge-history flop and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.slow_in};
            r_hist <= w_sync_out;
            r_rise <= w_rise;
            r_fall <= w_fall;
        end
    end

    // Cycles since the last rise; restarts at 1 on a rise and parks at TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != TMO) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Measurement FSM: a rise in MEASURE closes a period. A timeout from any
    // state drops back to IDLE. A rise on the timeout cycle takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_stalled      <= 1'b0;
            r_err          <= '0;
            r_good         <= '0;
        end else begin
            r_period_valid <= 1'b0;
            if (w_rise) begin
                r_stalled <= 1'b0;
                case (r_state)
                    IDLE: begin
                        r_state <= MEASURE;
                    end
                    MEASURE: begin
                        r_period       <= r_cnt;
                        r_period_valid <= 1'b1;
                        if (w_in_tol) begin
                            r_good   <= w_good_next;
                            r_locked <= (w_good_next == LOCK_V);
                        end else begin
                            r_good   <= '0;
                            r_locked <= 1'b0;
                            r_err    <= w_err_next;
                        end
                    end
                endcase
            end else if (w_stall_hit) begin
                r_stalled <= 1'b1;
                r_locked  <= 1'b0;
                r_good    <= '0;
                r_err     <= w_err_next;
                r_state   <= IDLE;
            end
        end
    end

    assign bus.rise_pulse   = r_rise;
    assign bus.fall_pulse   = r_fall;
    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.locked       = r_locked;
    assign bus.stalled      = r_stalled;
    assign bus.err_count    = r_err;
    assign bus.dbg_measure  = (r_state == MEASURE);

endmodule
